// File: rtl/cc_pkg.sv
// Shared types and width helpers for the cache refill controller.
//   cc_refill_state_t : refill sequencer states
//   cc_beat_w/off_w/tag_w : widths derived from the cache geometry
package cc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_REQ,
    ST_FILL,
    ST_UPD,
    ST_DONE
  } cc_refill_state_t;

  // Beat-position width within a line.
  function automatic int unsigned cc_beat_w(input int unsigned beats);
    return $clog2(beats);
  endfunction

  // Line byte-offset width.
  function automatic int unsigned cc_off_w(input int unsigned beats, input int unsigned data_w);
    return $clog2(beats * data_w / 8);
  endfunction

  // Tag width left over after index and offset.
  function automatic int unsigned cc_tag_w(input int unsigned addr_w, input int unsigned index_w,
                                           input int unsigned off_w);
    return addr_w - index_w - off_w;
  endfunction

endpackage

// File: rtl/cc_refill_ctrl.sv
// Miss/refill sequencer for the 2-way set-associative cache.
// Picks a victim way (invalid first, else the LFSR way), bursts the line in
// from memory writing each beat to the data array, then writes tag/valid and
// acknowledges the miss.
// Ports:
//   miss_req_i/miss_addr_i/miss_ack_o : lookup pipeline request/ack
//   valid0_i/valid1_i                 : valid bits of both ways at the miss index
//   way_rand_i/way_update_o           : LFSR way selector interface
//   mem_ar*/mem_r*                    : memory burst read port
//   wr_*                              : data-array write port
//   tag_wr_o/tag_o                    : tag-array write port
//   busy_o/err_o                      : status (err_o sticky until reset)
module cc_refill_ctrl
  import cc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned INDEX_W = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              miss_req_i,
  input  logic [ADDR_W-1:0]                 miss_addr_i,
  output logic                              miss_ack_o,
  input  logic                              valid0_i,
  input  logic                              valid1_i,
  input  logic                              way_rand_i,
  output logic                              way_update_o,
  output logic                              mem_arvalid_o,
  input  logic                              mem_arready_i,
  output logic [ADDR_W-1:0]                 mem_araddr_o,
  input  logic                              mem_rvalid_i,
  input  logic [DATA_W-1:0]                 mem_rdata_i,
  input  logic                              mem_rlast_i,
  output logic                              mem_rready_o,
  output logic                              wr_en_o,
  output logic                              wr_way_o,
  output logic [INDEX_W-1:0]                wr_index_o,
  output logic [$clog2(BEATS)-1:0]          wr_beat_o,
  output logic [DATA_W-1:0]                 wr_data_o,
  output logic                              tag_wr_o,
  output logic [ADDR_W-INDEX_W-$clog2(BEATS*DATA_W/8)-1:0] tag_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int unsigned BEAT_W = cc_beat_w(BEATS);
  localparam int unsigned OFF_W  = cc_off_w(BEATS, DATA_W);
  localparam int unsigned TAG_W  = cc_tag_w(ADDR_W, INDEX_W, OFF_W);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

  cc_refill_state_t    state_q, state_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                way_q, way_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_beat;

  assign last_beat = (cnt_q == BEAT_W'(BEATS - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      way_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      way_q   <= way_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    way_d         = way_q;
    addr_d        = addr_q;
    miss_ack_o    = 1'b0;
    way_update_o  = 1'b0;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    wr_en_o       = 1'b0;
    tag_wr_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (miss_req_i) begin
          addr_d  = miss_addr_i & LINE_MASK;
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        // Invalid way wins; the LFSR only advances when it was consulted.
        if (!valid0_i) begin
          way_d = 1'b0;
        end else if (!valid1_i) begin
          way_d = 1'b1;
        end else begin
          way_d        = way_rand_i;
          way_update_o = 1'b1;
        end
        state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) state_d = ST_FILL;
      end
      ST_FILL: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i) begin
          wr_en_o = 1'b1;
          // The beat count ends the burst; rlast is only cross-checked.
          if (mem_rlast_i != last_beat) err_d = 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_UPD;
          end else begin
            cnt_d = cnt_q + BEAT_W'(1);
          end
        end
      end
      ST_UPD: begin
        tag_wr_o = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        miss_ack_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_araddr_o = addr_q;
  assign wr_way_o     = way_q;
  assign wr_index_o   = addr_q[OFF_W +: INDEX_W];
  assign wr_beat_o    = cnt_q;
  assign wr_data_o    = wr_en_o ? mem_rdata_i : '0;
  assign tag_o        = addr_q[ADDR_W-1 -: TAG_W];
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_cc_refill_ctrl.sv
// Self-checking bench for cc_refill_ctrl (default geometry: 32-bit address,
// 32-bit beats, 4 beats/line, 6 index bits -> 4 offset bits, 22 tag bits).
module tb_cc_refill_ctrl;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BEATS   = 4;
  localparam int unsigned INDEX_W = 6;
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned TAG_W   = 22;

  logic clk = 1'b0;
  logic rst_n;
  logic miss_req_i;
  logic [ADDR_W-1:0] miss_addr_i;
  logic miss_ack_o;
  logic valid0_i, valid1_i, way_rand_i, way_update_o;
  logic mem_arvalid_o, mem_arready_i;
  logic [ADDR_W-1:0] mem_araddr_o;
  logic mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic mem_rlast_i, mem_rready_o;
  logic wr_en_o, wr_way_o;
  logic [INDEX_W-1:0] wr_index_o;
  logic [1:0] wr_beat_o;
  logic [DATA_W-1:0] wr_data_o;
  logic tag_wr_o;
  logic [TAG_W-1:0] tag_o;
  logic busy_o, err_o;

  always #5 clk = ~clk;

  cc_refill_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .INDEX_W(INDEX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i), .miss_ack_o(miss_ack_o),
    .valid0_i(valid0_i), .valid1_i(valid1_i),
    .way_rand_i(way_rand_i), .way_update_o(way_update_o),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i), .mem_araddr_o(mem_araddr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
    .mem_rready_o(mem_rready_o),
    .wr_en_o(wr_en_o), .wr_way_o(wr_way_o), .wr_index_o(wr_index_o),
    .wr_beat_o(wr_beat_o), .wr_data_o(wr_data_o),
    .tag_wr_o(tag_wr_o), .tag_o(tag_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [1:0]        beat;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Peer way-selector LFSR model driving way_rand_i.
  logic [7:0] lfsr = 8'hA7;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Per-miss observations.
  int r_ack_cyc, r_tag_cyc, r_first_wr, r_last_wr, r_wr_cnt, r_upd_cnt, r_tag_cnt;
  bit r_way, r_rand_at_sel, r_ar_bad, r_aborted, r_busy_after;
  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_index;

  // Run one miss with a reactive memory; cycle 0 is the request cycle.
  task automatic do_miss(input logic [ADDR_W-1:0] addr, input bit v0, input bit v1,
                         input int ar_wait, input int gap_beat, input int gap_len,
                         input int rlast_at, input int abort_at);
    logic [DATA_W-1:0] line [BEATS];
    logic [ADDR_W-1:0] line_addr;
    int cyc, beat_idx, ar_seen, gap_left;
    bit done, accepted, upd_seen;
    beat_t e;
    r_ack_cyc = -1; r_tag_cyc = -1; r_first_wr = -1; r_last_wr = -1;
    r_wr_cnt = 0; r_upd_cnt = 0; r_tag_cnt = 0;
    r_way = 0; r_rand_at_sel = 0; r_ar_bad = 0; r_aborted = 0; r_busy_after = 1;
    r_tag = '0; r_index = '0;
    line_addr = addr & 32'hFFFF_FFF0;
    for (int b = 0; b < BEATS; b++) begin
      line[b] = $urandom;
      exp_q.push_back('{beat: 2'(b), data: line[b]});
    end
    @(posedge clk); #1;
    miss_req_i = 1'b1; miss_addr_i = addr; valid0_i = v0; valid1_i = v1;
    way_rand_i = lfsr[0];
    mem_arready_i = (ar_wait == 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = line[0]; mem_rlast_i = (rlast_at == 0);
    cyc = 0; beat_idx = 0; ar_seen = 0; gap_left = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (mem_arvalid_o) begin
        ar_seen++;
        if (mem_araddr_o !== line_addr) r_ar_bad = 1;
      end
      upd_seen = way_update_o;
      if (way_update_o) begin r_upd_cnt++; r_rand_at_sel = way_rand_i; end
      if (wr_en_o) begin
        r_wr_cnt++;
        if (r_first_wr < 0) r_first_wr = cyc;
        r_last_wr = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL wr_beat_unexpected got beat=%0d want no write", wr_beat_o);
        end else begin
          e = exp_q.pop_front();
          if ({wr_beat_o, wr_data_o, mem_rvalid_i} !== {e.beat, e.data, 1'b1}) begin
            bad++;
            $display("FAIL wr_beat got beat=%0d data=%h rvalid=%b want beat=%0d data=%h rvalid=1",
                     wr_beat_o, wr_data_o, mem_rvalid_i, e.beat, e.data);
          end
        end
      end
      if (tag_wr_o) begin
        r_tag_cnt++; r_tag_cyc = cyc; r_tag = tag_o; r_way = wr_way_o; r_index = wr_index_o;
      end
      accepted = mem_rvalid_i && mem_rready_o;
      if (miss_ack_o) begin r_ack_cyc = cyc; done = 1; end
      @(posedge clk); #1;
      cyc++;
      if (upd_seen) lfsr = lfsr_step(lfsr);
      way_rand_i = lfsr[0];
      if (accepted) begin
        beat_idx++;
        if (beat_idx - 1 == gap_beat) gap_left = gap_len;
      end
      if (gap_left > 0) begin
        mem_rvalid_i = 1'b0; gap_left--;
      end else begin
        mem_rvalid_i = (beat_idx < BEATS);
      end
      mem_rdata_i = (beat_idx < BEATS) ? line[beat_idx] : '0;
      mem_rlast_i = mem_rvalid_i && (beat_idx == rlast_at);
      mem_arready_i = (ar_seen >= ar_wait);
      if (done) begin
        miss_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_arready_i = 1'b0; mem_rlast_i = 1'b0;
      end
      if (abort_at >= 0 && beat_idx == abort_at) begin r_aborted = 1; done = 1; end
    end
    if (done && !r_aborted) begin
      @(negedge clk);
      r_busy_after = busy_o;
    end
  endtask

  task automatic test_reset();
    logic [111:0] outs;
    rst_n = 1'b0;
    miss_req_i = 0; miss_addr_i = '0; valid0_i = 0; valid1_i = 0; way_rand_i = 0;
    mem_arready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_rlast_i = 0;
    #12;
    outs = {miss_ack_o, way_update_o, mem_arvalid_o, mem_araddr_o, mem_rready_o, wr_en_o,
            wr_way_o, wr_index_o, wr_beat_o, wr_data_o, tag_wr_o, tag_o, busy_o, err_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy_o, err_o} !== 2'b00) begin bad++; $display("FAIL idle_after_reset got=%b want=00", {busy_o, err_o}); end
  endtask

  task automatic test_both_invalid();
    do_miss(32'h0000_1234, 0, 0, 0, -1, 0, BEATS - 1, -1);
    total++; if (r_ack_cyc !== 8) begin bad++; $display("FAIL ack_latency got=%0d want=8", r_ack_cyc); end
    total++; if (r_first_wr !== 3 || r_last_wr !== 6 || r_wr_cnt !== 4) begin
      bad++; $display("FAIL beat_timing got first=%0d last=%0d n=%0d want 3 6 4", r_first_wr, r_last_wr, r_wr_cnt); end
    total++; if (r_tag_cyc !== 7 || r_tag_cnt !== 1) begin
      bad++; $display("FAIL tag_wr_timing got cyc=%0d n=%0d want 7 1", r_tag_cyc, r_tag_cnt); end
    total++; if (r_upd_cnt !== 0) begin bad++; $display("FAIL way_update_invalid got=%0d want=0", r_upd_cnt); end
    total++; if (r_way !== 1'b0) begin bad++; $display("FAIL victim_way0 got=%b want=0", r_way); end
    total++; if (r_tag !== 22'h4 || r_index !== 6'h23) begin
      bad++; $display("FAIL tag_index got tag=%h idx=%h want 4 23", r_tag, r_index); end
    total++; if (r_ar_bad !== 0) begin bad++; $display("FAIL araddr got wrong want 00001230"); end
    total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL idle_after_ack got busy=%b want=0", r_busy_after); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL beats_left got=%0d want=0", exp_q.size()); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clean got=%b want=0", err_o); end
  endtask

  task automatic test_way1();
    do_miss(32'h0000_8A40, 1, 0, 0, -1, 0, BEATS - 1, -1);
    total++; if (r_way !== 1'b1 || r_upd_cnt !== 0) begin
      bad++; $display("FAIL victim_way1 got way=%b upd=%0d want 1 0", r_way, r_upd_cnt); end
    total++; if (r_ack_cyc !== 8) begin bad++; $display("FAIL ack_way1 got=%0d want=8", r_ack_cyc); end
  endtask

  task automatic test_way_lfsr();
    logic [7:0] m;
    logic [ADDR_W-1:0] a;
    bit exp_way;
    m = lfsr;
    for (int i = 0; i < 16; i++) begin
      exp_way = m[0];
      m = lfsr_step(m);
      a = $urandom;
      do_miss(a, 1, 1, 0, -1, 0, BEATS - 1, -1);
      total++;
      if (r_way !== exp_way || r_upd_cnt !== 1 || r_rand_at_sel !== exp_way) begin
        bad++; $display("FAIL lfsr_way[%0d] got way=%b upd=%0d rand=%b want way=%b upd=1",
                        i, r_way, r_upd_cnt, r_rand_at_sel, exp_way); end
      total++;
      if (r_index !== a[OFF_W +: INDEX_W] || r_ack_cyc !== 8) begin
        bad++; $display("FAIL lfsr_miss[%0d] got idx=%h ack=%0d want idx=%h ack=8",
                        i, r_index, r_ack_cyc, a[OFF_W +: INDEX_W]); end
    end
  endtask

  task automatic test_stalls();
    do_miss(32'h0001_0FFC, 0, 1, 3, 1, 2, BEATS - 1, -1);
    total++; if (r_ar_bad !== 0) begin bad++; $display("FAIL araddr_stall got unstable want 00010FF0"); end
    total++; if (r_wr_cnt !== 4 || exp_q.size() !== 0) begin
      bad++; $display("FAIL stall_beats got n=%0d left=%0d want 4 0", r_wr_cnt, exp_q.size()); end
    total++; if (r_ack_cyc !== 13) begin bad++; $display("FAIL stall_latency got=%0d want=13", r_ack_cyc); end
  endtask

  task automatic test_rlast_err();
    do_miss(32'h0000_2000, 1, 1, 0, -1, 0, 2, -1);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL rlast_err got=%b want=1", err_o); end
    total++; if (r_wr_cnt !== 4 || r_ack_cyc !== 8 || r_tag_cnt !== 1) begin
      bad++; $display("FAIL rlast_fill got n=%0d ack=%0d tag=%0d want 4 8 1", r_wr_cnt, r_ack_cyc, r_tag_cnt); end
    do_miss(32'h0000_3000, 0, 0, 0, -1, 0, BEATS - 1, -1);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err_o); end
  endtask

  task automatic test_reset_mid_fill();
    logic [111:0] outs;
    do_miss(32'h0000_4440, 0, 0, 0, -1, 0, BEATS - 1, 2);
    total++; if (r_aborted !== 1'b1 || busy_o !== 1'b1) begin
      bad++; $display("FAIL reach_fill got aborted=%b busy=%b want 1 1", r_aborted, busy_o); end
    #2 rst_n = 1'b0;
    #1;
    outs = {miss_ack_o, way_update_o, mem_arvalid_o, mem_araddr_o, mem_rready_o, wr_en_o,
            wr_way_o, wr_index_o, wr_beat_o, wr_data_o, tag_wr_o, tag_o, busy_o, err_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL async_reset_outputs got=%h want=0", outs); end
    total++; if (r_tag_cnt !== 0) begin bad++; $display("FAIL no_tag_wr got=%0d want=0", r_tag_cnt); end
    miss_req_i = 0; mem_rvalid_i = 0; mem_arready_i = 0; mem_rlast_i = 0;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    do_miss(32'h0000_5550, 0, 0, 0, -1, 0, BEATS - 1, -1);
    total++; if (r_ack_cyc !== 8 || r_wr_cnt !== 4 || r_tag_cnt !== 1 || err_o !== 1'b0) begin
      bad++; $display("FAIL post_reset_miss got ack=%0d n=%0d tag=%0d err=%b want 8 4 1 0",
                      r_ack_cyc, r_wr_cnt, r_tag_cnt, err_o); end
  endtask

  initial begin
    test_reset();
    test_both_invalid();
    test_way1();
    test_way_lfsr();
    test_stalls();
    test_rlast_err();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/cc_refill_ctrl.md
Name: cc_refill_ctrl

Overview:
Miss/refill sequencer for the 2-way set-associative cache.
- On a miss from the lookup pipeline, picks a victim way: invalid way first, otherwise the random way from the cache's LFSR way selector.
- Fetches the line from memory as a read burst, writes each beat into the data array, then writes the tag/valid entry and acknowledges the miss.
- Sits between the lookup pipeline, the way selector, the tag/data arrays and the memory read port.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, memory beat / data-array write width
BEATS, 4, beats per cache line (power of 2, >=2)
INDEX_W, 6, set index width
OFF_W, $clog2(BEATS*DATA_W/8), line byte-offset width (derived, not overridable)
TAG_W, ADDR_W-INDEX_W-OFF_W, tag width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
miss_req_i  in  1  refill request; held high until miss_ack_o
miss_addr_i  in  ADDR_W  miss address; stable while miss_req_i is high
miss_ack_o  out  1  one-cycle pulse: line installed
valid0_i  in  1  way-0 valid bit at the miss index
valid1_i  in  1  way-1 valid bit at the miss index
way_rand_i  in  1  random way from the way selector
way_update_o  out  1  one-cycle pulse advancing the way selector
mem_arvalid_o  out  1  burst read request valid
mem_arready_i  in  1  burst read request accepted
mem_araddr_o  out  ADDR_W  line-aligned burst address
mem_rvalid_i  in  1  read beat valid
mem_rdata_i  in  DATA_W  read beat data
mem_rlast_i  in  1  last beat marker
mem_rready_o  out  1  ready for read beat
wr_en_o  out  1  data-array write strobe
wr_way_o  out  1  victim way
wr_index_o  out  INDEX_W  set index
wr_beat_o  out  $clog2(BEATS)  beat position within the line
wr_data_o  out  DATA_W  beat data (mem_rdata_i passed through)
tag_wr_o  out  1  tag-array write strobe; sets valid
tag_o  out  TAG_W  tag to write
busy_o  out  1  high in every state except IDLE
err_o  out  1  sticky: mem_rlast_i disagreed with the beat count

Behaviour:
- States: IDLE, SEL, REQ, FILL, UPD, DONE. All outputs are Moore (state/register) outputs, except wr_en_o/wr_data_o which follow the mem_rvalid_i handshake.
- Reset: state=IDLE, beat counter=0, err_o=0, all outputs 0.
- IDLE: if miss_req_i, capture the tag, index and line-aligned address (offset bits zeroed) -> SEL. miss_req_i is sampled only in IDLE.
- SEL (1 cycle): victim way =
  - 0 if !valid0_i;
  - else 1 if !valid1_i;
  - else way_rand_i, with way_update_o=1 this cycle only.
  Victim is registered -> REQ.
- REQ: mem_arvalid_o=1 with mem_araddr_o held until mem_arready_i. Transfer in the same cycle as arready -> FILL.
- FILL: mem_rready_o=1. Each cycle with mem_rvalid_i high:
  - wr_en_o=1, wr_beat_o=counter, wr_data_o=mem_rdata_i;
  - counter++.
  - On the accepted beat with counter==BEATS-1: counter wraps to 0 -> UPD.
  - Stalls (rvalid low) hold state and counter indefinitely.
- rlast check: if mem_rlast_i != (counter==BEATS-1) on an accepted beat, err_o is set and held until reset. The beat count alone ends the burst.
- UPD (1 cycle): tag_wr_o=1, tag_o=captured tag, wr_way_o/wr_index_o valid -> DONE.
- DONE (1 cycle): miss_ack_o=1 -> IDLE. A new miss is accepted in IDLE the next cycle, so there is at least one idle cycle between ack and the next SEL.
- wr_way_o and wr_index_o are held stable from SEL exit through DONE.
- Latency: with zero wait states, ack arrives 4+BEATS cycles after the request cycle (8 for BEATS=4).
- Reset mid-operation: immediate return to IDLE; no tag_wr_o has been issued. The tag-array valid bits share this reset, so a partially filled line is never hit.

Decomposition:
- Shared package cc_pkg: state enum cc_refill_state_t; BEATS-derived widths; OFF_W/TAG_W helper functions.
- No sub-module. The FSM and beat counter are inline. The LFSR way selector is a separate peer instance connected via way_rand_i/way_update_o.

Test Plan:
- Both ways invalid, miss at 0x0000_1234, zero wait states:
  - araddr=0x0000_1230, wr_way_o=0;
  - beats 0..3 written on consecutive cycles;
  - tag_wr_o one cycle later, miss_ack_o 8 cycles after the request;
  - way_update_o never pulses.
- valid0=1, valid1=0 -> victim way 1; way_update_o stays 0.
- Both valid: way_update_o pulses exactly once in SEL, and wr_way_o equals way_rand_i sampled that cycle. Repeat 16 misses and check the recorded way sequence against the LFSR model.
- arready delayed 3 cycles and rvalid gaps between beats 1 and 2:
  - araddr stable throughout the wait;
  - exactly 4 wr_en_o pulses with wr_beat_o 0,1,2,3.
- rlast asserted on beat 2 (BEATS=4): err_o rises and stays high; fill still completes after 4 beats; ack issued.
- rst_n asserted asynchronously during FILL after 2 beats:
  - all outputs 0 immediately, no tag_wr_o, err_o=0;
  - a following miss completes normally.
